// File: rtl/grid_move_ctrl.sv
// Single-step player movement on a COLS x ROWS grid.
// Each request is checked for retreat, edge and wall violations, then committed or rejected with a reason code.
module grid_move_ctrl #(
   parameter int unsigned          COLS        = 8,
   parameter int unsigned          ROWS        = 4,
   parameter int unsigned          XW          = 3,
   parameter int unsigned          YW          = 2,
   parameter logic [ROWS*COLS-1:0] FORBID_MASK = (ROWS*COLS)'(32'h44451048),
   parameter int unsigned          FORBID_MODE = 0,
   parameter int unsigned          WRAP        = 0,
   parameter int unsigned          START_X     = 0,
   parameter int unsigned          START_Y     = 0,
   parameter int unsigned          CW          = 8
) (
   input  logic          clk_50MHz_i,
   input  logic          rst_async_ha_i,
   input  logic [2:0]    dir_i,
   input  logic          move_req_i,
   input  logic          restart_i,
   output logic [XW-1:0] pos_x_o,
   output logic [YW-1:0] pos_y_o,
   output logic [2:0]    last_dir_o,
   output logic          in_forbidden_o,
   output logic          move_done_o,
   output logic          move_rej_o,
   output logic [1:0]    rej_code_o,
   output logic [CW-1:0] move_cnt_o
);

   localparam logic [2:0] DIR_UP    = 3'b000;
   localparam logic [2:0] DIR_DOWN  = 3'b111;
   localparam logic [2:0] DIR_RIGHT = 3'b101;
   localparam logic [2:0] DIR_LEFT  = 3'b010;
   localparam logic [2:0] DIR_NONE  = 3'b100;

   localparam int unsigned  IW      = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
   localparam logic [XW:0]  X_MAX   = (XW + 1)'(COLS - 1);
   localparam logic [YW:0]  Y_MAX   = (YW + 1)'(ROWS - 1);
   localparam logic [XW:0]  X_ONE   = (XW + 1)'(1);
   localparam logic [YW:0]  Y_ONE   = (YW + 1)'(1);
   localparam logic [XW-1:0] START_XV = XW'(START_X);
   localparam logic [YW-1:0] START_YV = YW'(START_Y);

   if (FORBID_MODE == 1 && FORBID_MASK[START_Y * COLS + START_X]) begin : g_start_chk
      $error("grid_move_ctrl: START cell is forbidden in wall mode");
   end

   function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return IW'(y) * IW'(COLS) + IW'(x);
   endfunction

   logic [XW-1:0] pos_x_q, pos_x_d;
   logic [YW-1:0] pos_y_q, pos_y_d;
   logic [2:0]    last_dir_q, last_dir_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          rej_q, rej_d;
   logic [1:0]    code_q, code_d;

   logic [XW:0]   tx_w;
   logic [YW:0]   ty_w;
   logic [XW-1:0] tx;
   logic [YW-1:0] ty;
   logic          dir_ok, out_x, out_y;
   logic          retreat_bad, edge_bad, wall_bad;

   assign in_forbidden_o = FORBID_MASK[cell_idx(pos_x_q, pos_y_q)];

   // Target computed one bit wider so that 0-1 shows up as a large value above the max coordinate.
   always_comb begin
      tx_w   = {1'b0, pos_x_q};
      ty_w   = {1'b0, pos_y_q};
      dir_ok = 1'b1;
      case (dir_i)
         DIR_UP:    ty_w = {1'b0, pos_y_q} - Y_ONE;
         DIR_DOWN:  ty_w = {1'b0, pos_y_q} + Y_ONE;
         DIR_RIGHT: tx_w = {1'b0, pos_x_q} + X_ONE;
         DIR_LEFT:  tx_w = {1'b0, pos_x_q} - X_ONE;
         default:   dir_ok = 1'b0;
      endcase
      out_x = (tx_w > X_MAX);
      out_y = (ty_w > Y_MAX);

      tx = tx_w[XW-1:0];
      ty = ty_w[YW-1:0];
      if (out_x) tx = (dir_i == DIR_LEFT) ? X_MAX[XW-1:0] : '0;
      if (out_y) ty = (dir_i == DIR_UP)   ? Y_MAX[YW-1:0] : '0;

      retreat_bad = (FORBID_MODE == 0) && in_forbidden_o && (dir_i != ~last_dir_q);
      edge_bad    = (WRAP == 0) && (out_x || out_y);
      wall_bad    = (FORBID_MODE == 1) && FORBID_MASK[cell_idx(tx, ty)];
   end

   always_comb begin
      pos_x_d    = pos_x_q;
      pos_y_d    = pos_y_q;
      last_dir_d = last_dir_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      rej_d      = 1'b0;
      code_d     = 2'b00;
      if (restart_i) begin
         pos_x_d    = START_XV;
         pos_y_d    = START_YV;
         last_dir_d = DIR_NONE;
         cnt_d      = '0;
      end else if (move_req_i && dir_ok) begin
         if (retreat_bad) begin
            rej_d  = 1'b1;
            code_d = 2'b11;
         end else if (edge_bad) begin
            rej_d  = 1'b1;
            code_d = 2'b01;
         end else if (wall_bad) begin
            rej_d  = 1'b1;
            code_d = 2'b10;
         end else begin
            pos_x_d    = tx;
            pos_y_d    = ty;
            last_dir_d = dir_i;
            done_d     = 1'b1;
            cnt_d      = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_50MHz_i or posedge rst_async_ha_i) begin
      if (rst_async_ha_i) begin
         pos_x_q    <= START_XV;
         pos_y_q    <= START_YV;
         last_dir_q <= DIR_NONE;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         rej_q      <= 1'b0;
         code_q     <= 2'b00;
      end else begin
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
         last_dir_q <= last_dir_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         rej_q      <= rej_d;
         code_q     <= code_d;
      end
   end

   assign pos_x_o     = pos_x_q;
   assign pos_y_o     = pos_y_q;
   assign last_dir_o  = last_dir_q;
   assign move_cnt_o  = cnt_q;
   assign move_done_o = done_q;
   assign move_rej_o  = rej_q;
   assign rej_code_o  = code_q;

endmodule

// File: tb/tb_grid_move_ctrl.sv
// Five grid_move_ctrl configurations driven with shared stimulus and checked against a cell-level model.
module tb_grid_move_ctrl;
   localparam int N = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] dir;
   logic       req, restart;

   logic [2:0] px [N];
   logic [1:0] py [N];
   logic [2:0] ld [N];
   logic       inf[N], dn[N], rj[N];
   logic [1:0] rc [N];
   logic [7:0] cnt8[N-1];
   logic [1:0] cnt2;

   int checks = 0, failures = 0;

   int          cols [N] = '{8, 8, 8, 5, 8};
   int          rows [N] = '{4, 4, 4, 4, 4};
   logic [31:0] masks[N] = '{32'h44451048, 32'h44451048, 32'h44451048, 32'h00010842, 32'h44451048};
   int          mode [N] = '{0, 1, 0, 1, 0};
   int          wrapv[N] = '{0, 0, 1, 1, 0};
   int          cmax [N] = '{255, 255, 255, 255, 3};

   int mx[N], my[N], ml[N], mc[N], mdn[N], mrj[N], mrc[N];

   always #5 clk = ~clk;

   grid_move_ctrl u0 (.clk_50MHz_i(clk), .rst_async_ha_i(rst), .dir_i(dir), .move_req_i(req), .restart_i(restart),
      .pos_x_o(px[0]), .pos_y_o(py[0]), .last_dir_o(ld[0]), .in_forbidden_o(inf[0]), .move_done_o(dn[0]),
      .move_rej_o(rj[0]), .rej_code_o(rc[0]), .move_cnt_o(cnt8[0]));
   grid_move_ctrl #(.FORBID_MODE(1)) u1 (.clk_50MHz_i(clk), .rst_async_ha_i(rst), .dir_i(dir), .move_req_i(req),
      .restart_i(restart), .pos_x_o(px[1]), .pos_y_o(py[1]), .last_dir_o(ld[1]), .in_forbidden_o(inf[1]),
      .move_done_o(dn[1]), .move_rej_o(rj[1]), .rej_code_o(rc[1]), .move_cnt_o(cnt8[1]));
   grid_move_ctrl #(.WRAP(1)) u2 (.clk_50MHz_i(clk), .rst_async_ha_i(rst), .dir_i(dir), .move_req_i(req),
      .restart_i(restart), .pos_x_o(px[2]), .pos_y_o(py[2]), .last_dir_o(ld[2]), .in_forbidden_o(inf[2]),
      .move_done_o(dn[2]), .move_rej_o(rj[2]), .rej_code_o(rc[2]), .move_cnt_o(cnt8[2]));
   grid_move_ctrl #(.COLS(5), .FORBID_MASK(20'h10842), .FORBID_MODE(1), .WRAP(1)) u3 (.clk_50MHz_i(clk),
      .rst_async_ha_i(rst), .dir_i(dir), .move_req_i(req), .restart_i(restart), .pos_x_o(px[3]), .pos_y_o(py[3]),
      .last_dir_o(ld[3]), .in_forbidden_o(inf[3]), .move_done_o(dn[3]), .move_rej_o(rj[3]), .rej_code_o(rc[3]),
      .move_cnt_o(cnt8[3]));
   grid_move_ctrl #(.CW(2)) u4 (.clk_50MHz_i(clk), .rst_async_ha_i(rst), .dir_i(dir), .move_req_i(req),
      .restart_i(restart), .pos_x_o(px[4]), .pos_y_o(py[4]), .last_dir_o(ld[4]), .in_forbidden_o(inf[4]),
      .move_done_o(dn[4]), .move_rej_o(rj[4]), .rej_code_o(rc[4]), .move_cnt_o(cnt2));

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int mbit(input int i, input int x, input int y);
      return int'((masks[i] >> (y * cols[i] + x)) & 32'd1);
   endfunction

   function automatic int dut_cnt(input int i);
      if (i == 4) return int'(cnt2);
      else return int'(cnt8[i]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mx[i] = 0; my[i] = 0; ml[i] = 4; mc[i] = 0;
         mdn[i] = 0; mrj[i] = 0; mrc[i] = 0;
      end
   endtask

   task automatic model_step(input int d, input bit r, input bit rs);
      int dx, dy, nx, ny;
      bit valid, out;
      for (int i = 0; i < N; i++) begin
         mdn[i] = 0; mrj[i] = 0; mrc[i] = 0;
         dx = 0; dy = 0; valid = 1;
         case (d)
            0: dy = -1;
            7: dy = 1;
            5: dx = 1;
            2: dx = -1;
            default: valid = 0;
         endcase
         if (rs) begin
            mx[i] = 0; my[i] = 0; ml[i] = 4; mc[i] = 0;
         end else if (r && valid) begin
            nx = mx[i] + dx;
            ny = my[i] + dy;
            out = (nx < 0) || (nx >= cols[i]) || (ny < 0) || (ny >= rows[i]);
            if (mode[i] == 0 && mbit(i, mx[i], my[i]) == 1 && d != (7 - ml[i])) begin
               mrj[i] = 1; mrc[i] = 3;
            end else if (out && wrapv[i] == 0) begin
               mrj[i] = 1; mrc[i] = 1;
            end else begin
               nx = (nx + cols[i]) % cols[i];
               ny = (ny + rows[i]) % rows[i];
               if (mode[i] == 1 && mbit(i, nx, ny) == 1) begin
                  mrj[i] = 1; mrc[i] = 2;
               end else begin
                  mx[i] = nx; my[i] = ny; ml[i] = d; mdn[i] = 1;
                  if (mc[i] < cmax[i]) mc[i] = mc[i] + 1;
               end
            end
         end
      end
   endtask

   task automatic compare_all(input string ph);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("%s u%0d x", ph, i), int'(px[i]), mx[i]);
         chk($sformatf("%s u%0d y", ph, i), int'(py[i]), my[i]);
         chk($sformatf("%s u%0d last_dir", ph, i), int'(ld[i]), ml[i]);
         chk($sformatf("%s u%0d cnt", ph, i), dut_cnt(i), mc[i]);
         chk($sformatf("%s u%0d done", ph, i), int'(dn[i]), mdn[i]);
         chk($sformatf("%s u%0d rej", ph, i), int'(rj[i]), mrj[i]);
         chk($sformatf("%s u%0d code", ph, i), int'(rc[i]), mrc[i]);
         chk($sformatf("%s u%0d in_forb", ph, i), int'(inf[i]), mbit(i, my[i] >= 0 ? mx[i] : 0, my[i]));
      end
   endtask

   task automatic step(input string ph, input logic [2:0] d, input logic r, input logic rs);
      dir = d; req = r; restart = rs;
      @(posedge clk);
      model_step(int'(d), r, rs);
      @(negedge clk);
      compare_all(ph);
      $display("step %-8s dir=%b req=%b restart=%b u0=(%0d,%0d) cnt=%0d", ph, d, r, rs, px[0], py[0], cnt8[0]);
      req = 1'b0; restart = 1'b0;
   endtask

   initial begin
      rst = 1'b1; dir = 3'b100; req = 1'b0; restart = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      compare_all("reset");

      step("up_edge", 3'b000, 1'b1, 1'b0);
      chk("tp edge rej", int'(rj[0]), 1);
      chk("tp edge code", int'(rc[0]), 1);
      chk("tp edge cnt", int'(cnt8[0]), 0);

      step("restart", 3'b100, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) step("right", 3'b101, 1'b1, 1'b0);
      chk("tp retreat x", int'(px[0]), 3);
      chk("tp retreat inf", int'(inf[0]), 1);
      chk("tp wall code", int'(rc[1]), 2);
      chk("tp wall x", int'(px[1]), 2);
      chk("tp wall cnt", int'(cnt8[1]), 2);
      chk("tp wall last", int'(ld[1]), 5);
      step("down_rt", 3'b111, 1'b1, 1'b0);
      chk("tp retreat code", int'(rc[0]), 3);
      step("left_rt", 3'b010, 1'b1, 1'b0);
      chk("tp retreat back x", int'(px[0]), 2);
      chk("tp retreat cnt", int'(cnt8[0]), 4);

      step("restart", 3'b100, 1'b0, 1'b1);
      step("wrap_l", 3'b010, 1'b1, 1'b0);
      chk("tp wrap8 x", int'(px[2]), 7);
      chk("tp wrap5 x", int'(px[3]), 4);
      step("wrap_u", 3'b000, 1'b1, 1'b0);
      chk("tp wrap up y", int'(py[2]), 3);

      step("restart", 3'b100, 1'b0, 1'b1);
      step("sat1", 3'b101, 1'b1, 1'b0);
      step("sat2", 3'b101, 1'b1, 1'b0);
      step("sat3", 3'b111, 1'b1, 1'b0);
      step("sat4", 3'b000, 1'b1, 1'b0);
      step("sat5", 3'b111, 1'b1, 1'b0);
      chk("tp sat cnt", int'(cnt2), 3);
      step("rst_req", 3'b101, 1'b1, 1'b1);
      chk("tp restart cnt", int'(cnt2), 0);
      chk("tp restart last", int'(ld[4]), 4);
      chk("tp restart done", int'(dn[4]), 0);

      step("move", 3'b101, 1'b1, 1'b0);
      step("none", 3'b100, 1'b1, 1'b0);
      step("bad011", 3'b011, 1'b1, 1'b0);
      chk("tp ignore x", int'(px[0]), 1);
      chk("tp ignore pulse", int'(dn[0]) + int'(rj[0]), 0);

      for (int k = 0; k < 400; k++) begin
         step("rand", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
      end

      step("pre_ar", 3'b111, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1 model_reset();
      compare_all("arst");
      @(negedge clk);
      rst = 1'b0;
      step("post_ar", 3'b101, 1'b1, 1'b0);
      step("post_ar", 3'b111, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/grid_move_ctrl.md
# grid_move_ctrl

Parametrised player-movement controller for the game map. It holds the player's position in registers and accepts single-step direction requests. Each request is checked against the grid edges and a forbidden-cell mask, and is then either committed or rejected with a reason code. It sits between the input decoder, which supplies the direction code, and the room/display logic, which consumes the position.

## Interface
- COLS, 8: grid width in cells.
- ROWS, 4: grid height in cells.
- XW, 3: x-coordinate width; must satisfy 2^XW >= COLS.
- YW, 2: y-coordinate width; must satisfy 2^YW >= ROWS.
- FORBID_MASK, 32'h44451048: ROWS*COLS bits; bit index y*COLS+x, 1 = forbidden cell.
- FORBID_MODE, 0: 0 = retreat (cell may be entered, then only the reverse move is legal); 1 = wall (entry into a forbidden cell is rejected).
- WRAP, 0: 0 = moves off an edge are rejected; 1 = toroidal wrap.
- START_X, 0 / START_Y, 0: reset and restart cell.
- CW, 8: move-counter width.
- clk_50MHz_i  in  1  system clock, rising edge.
- rst_async_ha_i  in  1  asynchronous, active-high reset.
- dir_i  in  3  direction: UP=000, DOWN=111, RIGHT=101, LEFT=010, NONE=100.
- move_req_i  in  1  request strobe, sampled each rising edge.
- restart_i  in  1  synchronous return to the start cell.
- pos_x_o  out  XW  current x.
- pos_y_o  out  YW  current y.
- last_dir_o  out  3  direction of the last accepted move.
- in_forbidden_o  out  1  current cell is forbidden.
- move_done_o  out  1  one-cycle pulse: move committed.
- move_rej_o  out  1  one-cycle pulse: move rejected.
- rej_code_o  out  2  01 edge, 10 wall, 11 retreat violation; 00 when move_rej_o=0.
- move_cnt_o  out  CW  accepted moves, saturating.

## Operation
- Target cell:
  - UP: y-1. DOWN: y+1. RIGHT: x+1. LEFT: x-1.
  - The arithmetic is done one bit wider than the coordinate, so under/overflow is detectable against 0 and COLS-1/ROWS-1.
- Edge handling:
  - WRAP=0: an out-of-range target is rejected with code 01.
  - WRAP=1: x-1 from 0 gives COLS-1, and x+1 from COLS-1 gives 0. y behaves the same with ROWS. This must be correct for non-power-of-2 COLS/ROWS.
- Wall mode: a target with its mask bit set is rejected with code 10. The edge check has priority over the wall check.
- Retreat mode: while in_forbidden_o=1, a request is accepted only if dir_i == ~last_dir_o (bitwise complement). Any other direction is rejected with code 11. This check runs before the edge check.
- On accept:
  - position <= target, last_dir <= dir_i, move_done_o=1.
  - move_cnt increments and saturates at 2^CW-1.
- dir_i not in {UP, DOWN, RIGHT, LEFT}, including NONE: the request is ignored. No pulse is produced and no state changes.
- restart_i=1:
  - position <= START, last_dir <= NONE, counter <= 0.
  - move_done_o and move_rej_o stay 0.
  - It overrides a simultaneous move_req_i.
- in_forbidden_o is combinational from the position registers and FORBID_MASK.
- Elaboration error if the START cell is forbidden and FORBID_MODE=1.

## Timing
- Reset values:
  - pos = (START_X, START_Y), last_dir_o = NONE (100), move_cnt_o = 0.
  - move_done_o = move_rej_o = 0, rej_code_o = 00.
  - in_forbidden_o = FORBID_MASK[START_Y*COLS+START_X].
- Latency: a request sampled at edge N updates the position, last_dir, counter and pulses. All are visible after edge N and held for exactly one cycle for the pulses.
- Back-to-back requests on consecutive cycles are supported. Each request is evaluated against the position registered at its own edge, which already includes the previous move.
- Reset assertion mid-operation forces the reset values immediately, with no clock required. Deassertion is synchronised externally.
- All outputs are registered except in_forbidden_o.

## Test plan
- Reset, then UP at (0,0) with WRAP=0 -> move_rej_o=1, rej_code_o=01, pos stays (0,0), move_cnt_o=0.
- Retreat mode: RIGHT x3 from (0,0) -> pos (3,0), in_forbidden_o=1, cnt 3. Then DOWN -> rej code 11. Then LEFT -> pos (2,0), done=1, cnt 4.
- Wall mode: RIGHT x3 from (0,0) -> the third request is rejected with code 10, pos (2,0), cnt 2, last_dir_o=101.
- WRAP=1: LEFT at (0,0) -> pos (7,0). UP at (7,0) -> pos (7,3). Repeat with COLS=5: LEFT at (0,0) -> pos (4,0).
- CW=2: five accepted moves -> move_cnt_o saturates at 3. Then restart_i together with move_req_i -> pos (0,0), cnt 0, last_dir 100, no done/rej pulse.
- dir_i=NONE or 011 with move_req_i=1 -> no pulses and no state change. Async reset asserted mid-sequence -> all outputs return to reset values without a clock edge.
